// File: rtl/uart_tx_fifo_serializer_pkg.sv
// Shared UART TX definitions: FSM state encoding, parity-type
// constants and the parity helper used when a word is popped.
package uart_tx_fifo_serializer_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Wide enough to index up to 9 payload bits.
  localparam int IDX_W = 4;

  // Payload is zero-padded to 9 bits; padding does not alter the xor.
  function automatic logic parity_of(
    input logic [8:0] d,
    input logic       typ
  );
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, single clock, sync active-high reset.
// Ports: CLK, RST, push/wdata, pop/rdata (show-ahead), count, full, empty.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmitter with input FIFO, runtime prescale, parity, 1/2 stops.
// Ports: CLK, RST, P_DATA/Data_valid/ready, PAR_EN, PAR_TYP, STOP2,
//        PRESCALE, TX_OUT (idle high), busy, fifo_count.
module uart_tx_fifo_serializer
  import uart_tx_fifo_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_valid,
  output logic                          ready,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          TX_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int EW = DATA_WIDTH + 3;

  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign wdata = {STOP2, PAR_TYP, PAR_EN, P_DATA};
  assign ready = ~full;
  assign push  = Data_valid & ready;

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  uart_state_t             state, state_n;
  logic                    tx, tx_n;
  logic                    bsy, bsy_n;
  logic [PRESCALE_W-1:0]   cnt, cnt_n;
  logic [PRESCALE_W-1:0]   pre, pre_n;
  logic [DATA_WIDTH-1:0]   shreg, shreg_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    pen, pen_n;
  logic                    pbit, pbit_n;
  logic                    s2, s2_n;
  logic                    sidx, sidx_n;

  logic                    start_frame;
  logic                    bit_end;
  logic [PRESCALE_W-1:0]   pre_eff;
  logic [8:0]              pad;

  assign TX_OUT = tx;
  assign busy   = bsy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= UART_IDLE;
      tx    <= 1'b1;
      bsy   <= 1'b0;
      cnt   <= '0;
      pre   <= PRESCALE_W'(1);
      shreg <= '0;
      idx   <= '0;
      pen   <= 1'b0;
      pbit  <= 1'b0;
      s2    <= 1'b0;
      sidx  <= 1'b0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      bsy   <= bsy_n;
      cnt   <= cnt_n;
      pre   <= pre_n;
      shreg <= shreg_n;
      idx   <= idx_n;
      pen   <= pen_n;
      pbit  <= pbit_n;
      s2    <= s2_n;
      sidx  <= sidx_n;
    end
  end

  always_comb begin
    state_n     = state;
    tx_n        = tx;
    bsy_n       = bsy;
    cnt_n       = cnt;
    pre_n       = pre;
    shreg_n     = shreg;
    idx_n       = idx;
    pen_n       = pen;
    pbit_n      = pbit;
    s2_n        = s2;
    sidx_n      = sidx;
    pop         = 1'b0;
    start_frame = 1'b0;
    bit_end     = (cnt == '0);
    pre_eff     = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
    pad         = '0;
    pad[DATA_WIDTH-1:0] = rdata[DATA_WIDTH-1:0];

    // Bit-time counter reloads at every bit boundary.
    if (state != UART_IDLE)
      cnt_n = bit_end ? pre - 1'b1 : cnt - 1'b1;

    case (state)
      UART_IDLE: begin
        tx_n  = 1'b1;
        bsy_n = 1'b0;
        if (!empty) start_frame = 1'b1;
      end
      UART_START: begin
        if (bit_end) begin
          state_n = UART_DATA;
          tx_n    = shreg[0];
          idx_n   = '0;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            if (pen) begin
              state_n = UART_PARITY;
              tx_n    = pbit;
            end else begin
              state_n = UART_STOP;
              tx_n    = 1'b1;
              sidx_n  = 1'b0;
            end
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      UART_PARITY: begin
        if (bit_end) begin
          state_n = UART_STOP;
          tx_n    = 1'b1;
          sidx_n  = 1'b0;
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          if (s2 && !sidx) begin
            sidx_n = 1'b1;
          end else if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_n = UART_IDLE;
            tx_n    = 1'b1;
            bsy_n   = 1'b0;
          end
        end
      end
      default: begin
        state_n = UART_IDLE;
        tx_n    = 1'b1;
        bsy_n   = 1'b0;
      end
    endcase

    // Pop and latch the whole frame config so later input changes
    // cannot disturb the frame in flight.
    if (start_frame) begin
      pop     = 1'b1;
      state_n = UART_START;
      tx_n    = 1'b0;
      bsy_n   = 1'b1;
      pre_n   = pre_eff;
      cnt_n   = pre_eff - 1'b1;
      shreg_n = rdata[DATA_WIDTH-1:0];
      pen_n   = rdata[DATA_WIDTH];
      pbit_n  = parity_of(pad, rdata[DATA_WIDTH+1]);
      s2_n    = rdata[DATA_WIDTH+2];
      idx_n   = '0;
      sidx_n  = 1'b0;
    end
  end

endmodule
